// File: rtl/top_level_fresher_fsm_if.sv
// Board-level pin bundle for the constraint-entry controller: switches, buttons, camera pins, results.
// No handshake; master drives the pins, slave is the controller.
interface top_level_fresher_fsm_if;
    logic [15:0]  sw;
    logic         btnc;
    logic         btnu;
    logic         btnd;
    logic         btnr;
    logic         btnl;
    logic [7:0]   ja;
    logic [2:0]   jb;
    logic [119:0] constraints_out;
    logic         done;

    modport master (
        output sw, btnc, btnu, btnd, btnr, btnl, ja, jb,
        input  constraints_out, done
    );

    modport slave (
        input  sw, btnc, btnu, btnd, btnr, btnl, ja, jb,
        output constraints_out, done
    );
endinterface

// File: rtl/top_level_fresher_fsm.sv
// Button-driven editor for thirty 4-bit constraint slots; a press acts 2 edges after it is first sampled.
// No backpressure: one action per cycle, lower-priority simultaneous presses are dropped.
module top_level_fresher_fsm (
    input  logic                    clk_100mhz,
    input  logic                    reset_in,
    top_level_fresher_fsm_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EDIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] LAST_SLOT = 5'd29;

    // Bit order in the conditioning pipeline: {sw0, c, u, d, r, l}
    logic [5:0]   raw;
    logic [5:0]   sync1;
    logic [5:0]   sync2;
    logic [5:0]   edge_q;
    logic [5:0]   pulse;

    logic [1:0]   state;
    logic [4:0]   cursor;
    logic [119:0] slots;
    logic         done_q;

    logic [6:0]   slot_lsb;
    logic [3:0]   cur_slot;

    // The camera pins and spare switches are reserved; folded here so nothing downstream sees them.
    logic         unused_inputs;
    assign unused_inputs = ^{bus.sw[15:1], bus.ja, bus.jb};

    assign raw      = {bus.sw[0], bus.btnc, bus.btnu, bus.btnd, bus.btnr, bus.btnl};
    assign pulse    = sync2 & ~edge_q;
    assign slot_lsb = {cursor, 2'b00};
    assign cur_slot = slots[slot_lsb +: 4];

    always_ff @(posedge clk_100mhz) begin
        if (!reset_in) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
            state  <= IDLE;
            cursor <= '0;
            slots  <= '0;
            done_q <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            edge_q <= sync2;

            case (state)
                IDLE, DONE: begin
                    if (pulse[5]) begin
                        state  <= EDIT;
                        cursor <= '0;
                        slots  <= '0;
                        done_q <= 1'b0;
                    end
                end
                EDIT: begin
                    // Priority chain: confirm > up > down > right > left; start is ignored here
                    if (pulse[4]) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (pulse[3]) begin
                        slots[slot_lsb +: 4] <= cur_slot + 4'd1;
                    end else if (pulse[2]) begin
                        slots[slot_lsb +: 4] <= cur_slot - 4'd1;
                    end else if (pulse[1]) begin
                        cursor <= (cursor == LAST_SLOT) ? 5'd0 : cursor + 5'd1;
                    end else if (pulse[0]) begin
                        cursor <= (cursor == 5'd0) ? LAST_SLOT : cursor - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.constraints_out = slots;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_top_level_fresher_fsm.sv
// Directed bench for the constraint-entry controller: vector table plus multi-cycle corner sequences.
module tb_top_level_fresher_fsm;
    logic clk_100mhz = 1'b0;
    logic reset_in   = 1'b0;

    top_level_fresher_fsm_if bus();

    top_level_fresher_fsm dut (
        .clk_100mhz (clk_100mhz),
        .reset_in   (reset_in),
        .bus        (bus)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Button pattern bits: {sw0, c, u, d, r, l}
    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_SW   = 6'b100000;
    localparam logic [5:0] B_C    = 6'b010000;
    localparam logic [5:0] B_U    = 6'b001000;
    localparam logic [5:0] B_D    = 6'b000100;
    localparam logic [5:0] B_R    = 6'b000010;
    localparam logic [5:0] B_L    = 6'b000001;

    localparam logic [119:0] S29_1 = 120'h1 << 116;
    localparam logic [119:0] S29_2 = 120'h2 << 116;

    typedef struct {
        logic [5:0]   btn;
        logic [119:0] exp_c;
        logic         exp_d;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic drive(input logic [5:0] p);
        bus.sw   = {15'd0, p[5]};
        bus.btnc = p[4];
        bus.btnu = p[3];
        bus.btnd = p[2];
        bus.btnr = p[1];
        bus.btnl = p[0];
    endtask

    // One-period press, then enough idle cycles for the action to land and the edge register to clear
    task automatic press(input logic [5:0] p);
        drive(p);
        @(negedge clk_100mhz);
        drive(B_NONE);
        repeat (3) @(negedge clk_100mhz);
    endtask

    task automatic check(input string name, input logic [119:0] ec, input logic ed);
        checks++;
        if (bus.constraints_out !== ec || bus.done !== ed) begin
            errors++;
            $display("FAIL %s: got constraints=%h done=%b, want constraints=%h done=%b",
                     name, bus.constraints_out, bus.done, ec, ed);
        end
    endtask

    // Camera pins toggle randomly for the whole run
    initial begin
        bus.ja = '0;
        bus.jb = '0;
        forever begin
            @(negedge clk_100mhz);
            bus.ja = 8'($urandom);
            bus.jb = 3'($urandom);
        end
    end

    initial begin
        // Sequence after start+hold leaves slot0 = F, cursor 0, EDIT
        tbl[0]  = '{B_C,       120'hF,         1'b1};
        tbl[1]  = '{B_L,       120'hF,         1'b1};
        tbl[2]  = '{B_U,       120'hF,         1'b1};
        tbl[3]  = '{B_SW,      120'h0,         1'b0};
        tbl[4]  = '{B_L,       120'h0,         1'b0};
        tbl[5]  = '{B_U,       S29_1,          1'b0};
        tbl[6]  = '{B_U,       S29_2,          1'b0};
        tbl[7]  = '{B_R,       S29_2,          1'b0};
        tbl[8]  = '{B_D,       S29_2 | 120'hF, 1'b0};
        tbl[9]  = '{B_SW,      S29_2 | 120'hF, 1'b0};
        tbl[10] = '{B_U | B_R, S29_2,          1'b0};
        tbl[11] = '{B_U,       S29_2 | 120'h1, 1'b0};
        tbl[12] = '{B_D | B_L, S29_2,          1'b0};
        tbl[13] = '{B_C | B_U, S29_2,          1'b1};
        tbl[14] = '{B_D,       S29_2,          1'b1};
        tbl[15] = '{B_SW,      120'h0,         1'b0};
        tbl[16] = '{B_U,       120'h1,         1'b0};

        drive(B_NONE);
        reset_in = 1'b0;
        repeat (2) @(negedge clk_100mhz);
        check("reset_held", 120'h0, 1'b0);
        reset_in = 1'b1;
        @(negedge clk_100mhz);
        check("reset_released", 120'h0, 1'b0);

        press(B_U);
        check("idle_btnu", 120'h0, 1'b0);
        press(B_C);
        check("idle_btnc", 120'h0, 1'b0);
        press(B_D | B_L);
        check("idle_btnd_btnl", 120'h0, 1'b0);

        press(B_SW);
        check("start", 120'h0, 1'b0);

        // Hold btnd for three periods: one decrement, landing two edges after first sampling
        drive(B_D);
        @(negedge clk_100mhz);
        check("hold_after_k", 120'h0, 1'b0);
        @(negedge clk_100mhz);
        check("hold_after_k1", 120'h0, 1'b0);
        @(negedge clk_100mhz);
        check("hold_after_k2", 120'hF, 1'b0);
        drive(B_NONE);
        repeat (3) @(negedge clk_100mhz);
        check("hold_single_dec", 120'hF, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            press(tbl[i].btn);
            check($sformatf("vec%0d", i), tbl[i].exp_c, tbl[i].exp_d);
        end

        // Held press, one low sample, then a fresh press: two increments
        drive(B_U);
        repeat (3) @(negedge clk_100mhz);
        drive(B_NONE);
        @(negedge clk_100mhz);
        drive(B_U);
        @(negedge clk_100mhz);
        drive(B_NONE);
        repeat (3) @(negedge clk_100mhz);
        check("repress_after_release", 120'h3, 1'b0);

        // Reset mid-edit, with a simultaneous press that must be overridden
        drive(B_U);
        reset_in = 1'b0;
        @(negedge clk_100mhz);
        check("reset_mid_edit", 120'h0, 1'b0);
        reset_in = 1'b1;
        drive(B_NONE);
        repeat (3) @(negedge clk_100mhz);
        check("post_reset_quiet", 120'h0, 1'b0);
        press(B_U);
        check("post_reset_idle", 120'h0, 1'b0);
        press(B_SW);
        press(B_U);
        check("restart_after_reset", 120'h1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
